// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and default width for the serial adder
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   // 2'b11 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_FIN   = 2'b10
   } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// rtl/serial_adder_full_adder_cell.sv - single-bit combinational full adder
module full_adder_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder using one full-adder cell and a carry flop
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_c_out
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   sa_state_e        r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   // Only the upper WIDTH-1 partial-sum bits need storage; the newest bit comes from the cell.
   logic [WIDTH-1:1] r_sum_sr;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_c_out;
   logic             r_busy;
   logic             r_done;

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_next;

   full_adder_cell u_fa (
      .i_a    (r_a_sr[0]),
      .i_b    (r_b_sr[0]),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_co)
   );

   assign w_sum_next = {w_s, r_sum_sr};

   // Result is registered on the last shift so SUM/C_OUT are already valid while DONE is high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_c_out  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_a_sr   <= i_a;
                  r_b_sr   <= i_b;
                  r_carry  <= i_c_in;
                  r_sum_sr <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_sum_sr <= w_sum_next[WIDTH-1:1];
               r_carry  <= w_co;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_sum   <= w_sum_next;
                  r_c_out <= w_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end
            end
            ST_FIN: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_sum   = r_sum;
   assign o_c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and swept checks of serial_adder at WIDTH=8 and WIDTH=2
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       st8, c8, busy8, done8, co8;
   logic [7:0] a8, b8, sum8;
   logic       st2, c2, busy2, done2, co2;
   logic [1:0] a2, b2, sum2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_start(st8), .i_a(a8), .i_b(b8), .i_c_in(c8),
      .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_c_out(co8)
   );

   serial_adder #(.WIDTH(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(st2), .i_a(a2), .i_b(b2), .i_c_in(c2),
      .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_c_out(co2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 operation; operands are scrambled while it runs to prove they were captured.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic ec);
      int busy_n, done_at, done_n;
      bit stable;
      logic [7:0] prev;
      busy_n = 0; done_at = 0; done_n = 0; stable = 1'b1;
      @(negedge clk);
      prev = sum8; a8 = a; b8 = b; c8 = ci; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
         if (busy8) busy_n++;
         if (done8) begin
            done_n++;
            if (done_at == 0) begin
               done_at = n;
               check_eq({tag, " sum"}, sum8, es);
               check_eq({tag, " cout"}, co8, ec);
            end
         end else if (done_at == 0 && sum8 !== prev) begin
            stable = 1'b0;
         end
      end
      check_eq({tag, " busy_cycles"}, busy_n, 8);
      check_eq({tag, " done_cycle"}, done_at, 9);
      check_eq({tag, " done_count"}, done_n, 1);
      check_eq({tag, " sum_stable"}, stable, 1);
      check_eq({tag, " sum_hold"}, {co8, sum8}, {ec, es});
   endtask

   task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
      int busy_n, done_at;
      logic [2:0] exp;
      exp = {1'b0, a} + {1'b0, b} + {2'b00, ci};
      busy_n = 0; done_at = 0;
      @(negedge clk);
      a2 = a; b2 = b; c2 = ci; st2 = 1'b1;
      @(posedge clk); #1;
      st2 = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         a2 = ~a; b2 = ~b; c2 = ~ci;
         if (busy2) busy_n++;
         if (done2 && done_at == 0) begin
            done_at = n;
            check_eq($sformatf("w2 %0d+%0d+%0d result", a, b, ci), {co2, sum2}, exp);
         end
      end
      check_eq("w2 busy_cycles", busy_n, 2);
      check_eq("w2 done_cycle", done_at, 3);
   endtask

   initial begin
      int done_at, done_n;
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] rexp;

      rst = 1'b1;
      st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
      st2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst8 outputs", {busy8, done8, co8, sum8}, 11'h0);
      check_eq("rst2 outputs", {busy2, done2, co2, sum2}, 5'h0);
      rst = 1'b0;

      op8("zero",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      op8("ff_01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      op8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      op8("a5_5a",   8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
      op8("80_80_c", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

      // START held high: next capture happens in the first IDLE cycle after DONE.
      @(negedge clk);
      a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1;
      done_at = 0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (busy8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
         if (done8 && done_at == 0) begin
            done_at = n;
            check_eq("hold sum", {co8, sum8}, 9'h0FF);
         end
      end
      check_eq("hold done_cycle", done_at, 9);
      a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
      @(negedge clk);
      check_eq("hold idle_gap busy", busy8, 1'b0);
      @(posedge clk); #1;
      st8 = 1'b0;
      done_at = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (done8 && done_at == 0) begin
            done_at = n;
            check_eq("restart sum", {co8, sum8}, 9'h047);
         end
      end
      check_eq("restart done_cycle", done_at, 9);

      // Asynchronous reset in the middle of a shift sequence.
      @(negedge clk);
      a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b0; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1 check_eq("async rst outputs", {busy8, done8, co8, sum8}, 11'h0);
      done_n = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (n == 2) rst = 1'b0;
         if (done8) done_n++;
      end
      check_eq("rst no_done", done_n, 0);
      op8("post_rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

      for (int i = 0; i < 500; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
         rexp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         op8($sformatf("sweep%0d", i), ra, rb, rc, rexp[7:0], rexp[8]);
      end

      for (int i = 0; i < 32; i++) begin
         op2(2'(i >> 3), 2'(i >> 1), 1'(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full-adder cell plus a carry flip-flop.
- Loads two parallel operands on START and adds them LSB-first, one bit per clock.
- Presents a registered parallel SUM and C_OUT with a one-cycle DONE pulse.
- Trades latency for area: one full-adder instance replaces a WIDTH-bit ripple chain. This is the sequential consumer of the full-adder stage.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on an accepted START.
- B  input  WIDTH  operand B; captured on an accepted START.
- C_IN  input  1  carry-in; captured on an accepted START.
- BUSY  output  1  high while an addition is in progress (SHIFT state).
- DONE  output  1  one-cycle pulse when SUM/C_OUT are updated.
- SUM  output  WIDTH  registered result; holds the last completed sum.
- C_OUT  output  1  registered carry-out of the last completed sum.

Behaviour:
- Reset (RST high, asynchronous): state=IDLE; BUSY, DONE, C_OUT = 0; SUM = 0; all internal shift registers, carry flop and counter cleared.
- States:
  - IDLE: START=1 loads a_sr<=A, b_sr<=B, carry<=C_IN, sum_sr<=0, cnt<=0, then goes to SHIFT. START=0 stays in IDLE.
  - SHIFT, each cycle:
    - (s,co) = full_add(a_sr[0], b_sr[0], carry).
    - sum_sr <= {s, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one with zero fill; carry <= co; cnt <= cnt+1.
    - When cnt == WIDTH-1, the shift cycle is the last one: go to FIN.
  - FIN: SUM <= sum_sr, C_OUT <= carry, DONE=1 for this cycle only, then go to IDLE.
- BUSY = 1 exactly in SHIFT (WIDTH cycles). DONE = 1 exactly in FIN. Both are decoded from registered state, so they are glitch-free.
- Latency: START sampled at edge k → BUSY high for edges k+1..k+WIDTH → DONE high in the cycle after edge k+WIDTH, with SUM/C_OUT valid from that cycle.
- Throughput: one addition per WIDTH+2 cycles. A START held continuously restarts in the first IDLE cycle after FIN.
- START while in SHIFT or FIN: ignored; the operands in flight are unaffected.
- Changes on A/B/C_IN after capture: no effect on the operation in progress.
- SUM/C_OUT change only in FIN. They never show partial sums and hold their value until the next FIN or reset.
- Arithmetic: {C_OUT, SUM} = A + B + C_IN, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: aborts immediately, returns to IDLE, clears SUM/C_OUT; no DONE pulse.
- Counter width: clog2(WIDTH) bits, enough to hold WIDTH-1; never wraps within one operation.

Decomposition:
- Shared defs header serial_adder_defs holds:
  - state encodings IDLE=2'b00, SHIFT=2'b01, FIN=2'b10; 2'b11 is illegal and decodes to IDLE.
  - the default WIDTH constant.
- One sub-module, full_adder_cell: pure combinational, ports a, b, cin, s, cout, with s = a^b^cin and cout = majority(a,b,cin).
- Instantiated once, inside the SHIFT datapath.

Test Plan:
- WIDTH=8, A=8'h00, B=8'h00, C_IN=0, START for 1 cycle → BUSY for 8 cycles, DONE in cycle 9 after START, SUM=8'h00, C_OUT=0.
- A=8'hFF, B=8'h01, C_IN=0 → SUM=8'h00, C_OUT=1. Then A=8'hFF, B=8'hFF, C_IN=1 → SUM=8'hFF, C_OUT=1.
- A=8'hA5, B=8'h5A, C_IN=0; hold START high and toggle A/B during BUSY → SUM=8'hFF, C_OUT=0. Next op starts the first IDLE cycle after DONE and uses the A/B values present at that edge.
- Start A=8'h3C, B=8'h0F; assert RST asynchronously (mid-cycle) after 4 SHIFT cycles → BUSY, DONE, SUM, C_OUT go to 0 without waiting for a clock edge; no DONE. Release RST, then run A=8'h12, B=8'h34, C_IN=1 → SUM=8'h47, C_OUT=0.
- Randomised sweep of 500 operands plus C_IN checked against the A+B+C_IN reference → exact match, DONE exactly once per START, and SUM stable between DONE pulses.
- WIDTH=2 instance, exhaustive 32 input combinations → correct {C_OUT,SUM} each time, DONE 3 cycles after START.
